// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster pixel stream into registered CIN x F x F sliding windows.
// Define CONV_WIN_STRIDE2_EN to emit only windows whose top-left corner sits on an even row and column.
module conv_window_gen #(
   parameter int WIDTH = 8,
   parameter int CIN   = 3,
   parameter int F     = 5,
   parameter int IMG_W = 32,
   parameter int IMG_H = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CIN*WIDTH-1:0] in_pix,
   output logic                 win_valid,
   input  logic                 win_ready,
   output logic [WIDTH-1:0]     win [0:CIN*F*F-1],
   output logic                 frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PW = CIN * WIDTH;
   localparam int NE = CIN * F * F;
`ifdef CONV_WIN_STRIDE2_EN
   localparam logic EMIT_PAR = 1'((F - 1) % 2);
`endif

   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic             win_valid_q, win_valid_d;
   logic             frame_done_q, frame_done_d;
   logic [WIDTH-1:0] win_q [NE];
   logic [WIDTH-1:0] win_d [NE];

   // cur_col[r]: window row r of the column being completed by the incoming pixel.
   logic [F-1:0][PW-1:0]        cur_col;
   logic [F-2:0][F-1:0][PW-1:0] shift_q;

   logic accept;
   logic emit;
   logic last_col;
   logic last_row;

   assign in_ready = !win_valid_q || win_ready;
   assign accept   = in_valid && in_ready;
   assign last_col = (col_q == CW'(IMG_W - 1));
   assign last_row = (row_q == RW'(IMG_H - 1));

   // Line buffer g_lb[0] holds the oldest row; each accept moves that column up by one row.
   for (genvar r = 0; r < F - 1; r++) begin : g_lb
      logic [PW-1:0] mem_q [IMG_W];

      // NOTE: line-buffer RAM has no reset; emit gating keeps stale rows from ever reaching win.
      always_ff @(posedge clk) begin
         if (accept) begin
            mem_q[col_q] <= cur_col[r+1];
         end
      end

      assign cur_col[r] = mem_q[col_q];
   end

   assign cur_col[F-1] = in_pix;

   always_ff @(posedge clk) begin
      if (accept) begin
         shift_q <= {cur_col, shift_q[F-2:1]};
      end
   end

   always_comb begin
      emit = accept && (row_q >= RW'(F - 1)) && (col_q >= CW'(F - 1));
`ifdef CONV_WIN_STRIDE2_EN
      emit = emit && (row_q[0] == EMIT_PAR) && (col_q[0] == EMIT_PAR);
`endif
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      frame_done_d = 1'b0;
      if (accept) begin
         if (last_col) begin
            col_d = '0;
            if (last_row) begin
               row_d        = '0;
               frame_done_d = 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_comb begin
      win_d       = win_q;
      win_valid_d = win_valid_q;
      if (emit) begin
         win_valid_d = 1'b1;
         for (int c = 0; c < CIN; c++) begin
            for (int r = 0; r < F; r++) begin
               for (int k = 0; k < F - 1; k++) begin
                  win_d[c*F*F + r*F + k] = shift_q[k][r][c*WIDTH +: WIDTH];
               end
               win_d[c*F*F + r*F + F - 1] = cur_col[r][c*WIDTH +: WIDTH];
            end
         end
      end else if (win_ready) begin
         win_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         win_q        <= '{default: '0};
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         win_q        <= win_d;
      end
   end

   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;
   assign win        = win_q;

endmodule
